// File: rtl/gcd_arbiter_pkg.sv
// Shared types and helpers for the GCD arbiter: FSM encoding, default width,
// and the round-robin winner search.
package gcd_arb_pkg;

  localparam int DEF_W = 8;
  localparam int MAX_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req at or above ptr, wrapping within the n live lines.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input logic [2:0]       ptr,
                                    input int               n);
    pick_t p;
    int    idx;
    p.found = 1'b0;
    p.idx   = 3'd0;
    for (int k = 0; k < MAX_N; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !p.found && req[idx[2:0]]) begin
        p.found = 1'b1;
        p.idx   = idx[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/gcd_arbiter_if.sv
// Requester-side bundle of the GCD arbiter: operands and request in, grant,
// completion pulse, result and error out.
interface gcd_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic           err;

  modport master (
    output req, a_in, b_in,
    input  grant, done, result, err
  );

  modport slave (
    input  req, a_in, b_in,
    output grant, done, result, err
  );
endinterface

// File: rtl/gcd_arbiter_core.sv
// Subtract-based GCD datapath. Operands are captured the cycle after start;
// result is valid only while ready is high.
//
// state  | meaning
// C_IDLE | waiting for start
// C_LOAD | capturing operands from a/b
// C_RUN  | subtracting the smaller from the larger until both match
module gcd_core #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         ready
);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_LOAD = 2'd1,
    C_RUN  = 2'd2
  } core_state_t;

  core_state_t  state, state_next;
  logic [W-1:0] x, y;

  always_ff @(posedge clk) begin
    if (rst) state <= C_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    result     = '0;
    case (state)
      C_IDLE: if (start) state_next = C_LOAD;
      C_LOAD: state_next = C_RUN;
      C_RUN: begin
        if (x == y) begin
          ready      = 1'b1;
          result     = x;
          state_next = C_IDLE;
        end
      end
      default: state_next = C_IDLE;
    endcase
  end

  // A zero operand never converges here; the arbiter keeps such pairs away.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else begin
      case (state)
        C_LOAD: begin
          x <= a;
          y <= b;
        end
        C_RUN: begin
          if (x > y)      x <= x - y;
          else if (y > x) y <= y - x;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one gcd_core among N requesters, with a
// zero-operand bypass and a watchdog that aborts hung computations.
//
// state    | meaning
// ST_IDLE  | no service; pick a winner from req and latch its operands
// ST_ISSUE | bypass zero operands, else start the core and clear the watchdog
// ST_WAIT  | waiting for core ready; abort once the watchdog hits TMO
// ST_RESP  | pulse done for the winner and advance the pointer
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = DEF_W,
  parameter int TMO = 1023
) (
  input  logic          clk,
  input  logic          rst,
  gcd_arbiter_if.slave  bus
);

  localparam int CW = $clog2(TMO + 1);

  arb_state_t       state, state_next;
  logic [2:0]       ptr;
  logic [2:0]       win;
  logic [W-1:0]     a_r, b_r, res;
  logic             err_r;
  logic [CW-1:0]    wd;
  logic [MAX_N-1:0] req_pad;
  pick_t            pick;
  logic             bypass;
  logic             wd_hit;
  logic [N-1:0]     win_hot;
  logic             core_start;
  logic             core_abort;
  logic             core_rst;
  logic             core_ready;
  logic [W-1:0]     core_result;

  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = bus.req;
  end

  assign pick    = rr_pick(req_pad, ptr, N);
  assign bypass  = (a_r == '0) || (b_r == '0);
  assign wd_hit  = (wd == CW'(TMO));
  assign win_hot = {{(N-1){1'b0}}, 1'b1} << win;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    core_start = 1'b0;
    core_abort = 1'b0;
    case (state)
      ST_IDLE: if (pick.found) state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (bypass) begin
          state_next = ST_RESP;
        end else begin
          core_start = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_ready) begin
          state_next = ST_RESP;
        end else if (wd_hit) begin
          core_abort = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.grant  = (state != ST_IDLE) ? win_hot : '0;
  assign bus.done   = (state == ST_RESP) ? win_hot : '0;
  assign bus.result = (state == ST_RESP) ? res     : '0;
  assign bus.err    = (state == ST_RESP) ? err_r   : 1'b0;

  // The core is reset both with the block and on a watchdog abort.
  assign core_rst = rst | core_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= 3'd0;
      win   <= 3'd0;
      a_r   <= '0;
      b_r   <= '0;
      res   <= '0;
      err_r <= 1'b0;
      wd    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick.found) begin
            win <= pick.idx;
            a_r <= bus.a_in[int'(pick.idx)*W +: W];
            b_r <= bus.b_in[int'(pick.idx)*W +: W];
          end
        end
        ST_ISSUE: begin
          if (bypass) begin
            res   <= a_r | b_r;
            err_r <= 1'b0;
          end else begin
            wd <= '0;
          end
        end
        ST_WAIT: begin
          if (core_ready) begin
            res   <= core_result;
            err_r <= 1'b0;
          end else if (wd_hit) begin
            res   <= '0;
            err_r <= 1'b1;
          end else begin
            wd <= wd + CW'(1);
          end
        end
        ST_RESP: ptr <= (win == 3'(N-1)) ? 3'd0 : win + 3'd1;
        default: ;
      endcase
    end
  end

  gcd_core #(.W(W)) u_core (
    .clk    (clk),
    .rst    (core_rst),
    .start  (core_start),
    .a      (a_r),
    .b      (b_r),
    .result (core_result),
    .ready  (core_ready)
  );

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: directed scenarios plus randomized rounds checked
// against a Euclid/round-robin reference model.
module tb_gcd_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gcd_arbiter_if #(.N(4), .W(8)) bus ();
  gcd_arbiter_if #(.N(4), .W(8)) wbus ();

  gcd_arbiter #(.N(4), .W(8), .TMO(1023)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  gcd_arbiter #(.N(4), .W(8), .TMO(16)) u_wd (
    .clk (clk),
    .rst (rst),
    .bus (wbus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;
  int ptr_m   = 0;
  int op_a[4];
  int op_b[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int rr_ref(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    op_a[i] = a;
    op_b[i] = b;
    bus.a_in[i*8 +: 8] = 8'(a);
    bus.b_in[i*8 +: 8] = 8'(b);
  endtask

  task automatic wait_done(output int idx, output logic [7:0] res, output logic e,
                           output int cyc, output logic [3:0] gor, output int ghi,
                           output logic saw_start);
    idx = -1; res = '0; e = 1'b0; cyc = -1; gor = '0; ghi = 0; saw_start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      gor |= bus.grant;
      if (bus.grant != 0) ghi++;
      if (u_dut.core_start) saw_start = 1'b1;
      if (bus.done != 0) begin
        cyc = c;
        res = bus.result;
        e   = bus.err;
        for (int k = 0; k < 4; k++) if (bus.done[k]) idx = k;
        chk("done_onehot", $countones(bus.done), 1);
        return;
      end
    end
  endtask

  task automatic serve(input logic [3:0] keep, output int idx);
    int exp_idx, cyc, ghi;
    logic [7:0] res;
    logic e, ss;
    logic [3:0] gor;
    exp_idx = rr_ref(bus.req, ptr_m);
    wait_done(idx, res, e, cyc, gor, ghi, ss);
    chk("serve_in_time", cyc > 0, 1);
    if (cyc <= 0) begin
      idx = -1;
      return;
    end
    chk("serve_winner", idx, exp_idx);
    chk("serve_result", res, gcd_ref(op_a[idx], op_b[idx]));
    chk("serve_err", e, 0);
    if (!keep[idx]) bus.req[idx] = 1'b0;
    ptr_m = (idx + 1) % 4;
  endtask

  task automatic wait_start(output logic seen);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (u_dut.core_start) seen = 1'b1;
    end
  endtask

  initial begin
    int idx, cyc, ghi, cnt, aborts, ra, rb;
    logic [7:0] res;
    logic e, ss, seen;
    logic [3:0] gor;

    rst = 1'b1;
    bus.req = '0;  bus.a_in = '0;  bus.b_in = '0;
    wbus.req = '0; wbus.a_in = '0; wbus.b_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", bus.grant, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_core_start", u_dut.core_start, 0);
    chk("rst_ptr", u_dut.ptr, 0);
    rst = 1'b0;
    ptr_m = 0;

    // single request through the core
    set_op(0, 12, 8);
    bus.req[0] = 1'b1;
    wait_done(idx, res, e, cyc, gor, ghi, ss);
    chk("single_idx", idx, 0);
    chk("single_result", res, 4);
    chk("single_err", e, 0);
    chk("single_grant_bits", gor, 4'b0001);
    chk("single_grant_span", ghi, cyc);
    chk("single_used_core", ss, 1);
    bus.req[0] = 1'b0;
    ptr_m = 1;
    @(negedge clk);
    chk("single_pulse_len", bus.done, 0);
    chk("single_grant_idle", bus.grant, 0);

    // zero-operand bypass
    set_op(2, 0, 9);
    bus.req[2] = 1'b1;
    wait_done(idx, res, e, cyc, gor, ghi, ss);
    chk("byp_idx", idx, 2);
    chk("byp_result", res, 9);
    chk("byp_latency", cyc, 2);
    chk("byp_no_start", ss, 0);
    bus.req[2] = 1'b0;
    @(negedge clk);
    set_op(2, 0, 0);
    bus.req[2] = 1'b1;
    wait_done(idx, res, e, cyc, gor, ghi, ss);
    chk("byp00_result", res, 0);
    chk("byp00_latency", cyc, 2);
    chk("byp00_no_start", ss, 0);
    bus.req[2] = 1'b0;
    ptr_m = 3;

    // fairness from a fresh pointer
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    set_op(0, 12, 8);
    set_op(1, 7, 7);
    set_op(2, 255, 1);
    set_op(3, 35, 21);
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      serve(4'b0000, idx);
      chk("fair_order", idx, k);
    end
    bus.req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      serve(4'b1001, idx);
      chk("keep_order", idx, (k % 2 == 0) ? 0 : 3);
    end
    bus.req = '0;

    // randomized rounds
    for (int r = 0; r < 15; r++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        ra = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
        rb = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
        set_op(i, ra, rb);
      end
      bus.req = m;
      for (int k = 0; k < 4 && bus.req != 0; k++) begin
        serve(4'b0000, idx);
        if (idx < 0) break;
      end
      bus.req = '0;
      @(negedge clk);
    end

    // requester drops req while its computation is in flight
    set_op(1, 100, 75);
    bus.req[1] = 1'b1;
    wait_start(seen);
    chk("drop_started", seen, 1);
    @(negedge clk);
    bus.req[1] = 1'b0;
    wait_done(idx, res, e, cyc, gor, ghi, ss);
    chk("drop_idx", idx, 1);
    chk("drop_result", res, 25);
    ptr_m = 2;
    @(negedge clk);

    // reset in the middle of WAIT
    set_op(1, 48, 18);
    bus.req[1] = 1'b1;
    wait_start(seen);
    chk("mid_started", seen, 1);
    @(negedge clk);
    chk("mid_no_early_done", bus.done, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_grant", bus.grant, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_result", bus.result, 0);
    chk("mid_err", bus.err, 0);
    chk("mid_ptr", u_dut.ptr, 0);
    rst = 1'b0;
    ptr_m = 0;
    wait_done(idx, res, e, cyc, gor, ghi, ss);
    chk("mid_reissue_idx", idx, 1);
    chk("mid_reissue_result", res, 6);
    bus.req[1] = 1'b0;
    @(negedge clk);

    // watchdog abort on the short-timeout instance
    wbus.a_in[0 +: 8] = 8'd255;
    wbus.b_in[0 +: 8] = 8'd1;
    wbus.req[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (u_wd.core_start) seen = 1'b1;
    end
    chk("wd_started", seen, 1);
    cnt = 0;
    aborts = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      cnt++;
      if (u_wd.core_rst) aborts++;
      if (wbus.done != 0) break;
    end
    chk("wd_latency", cnt, 18);
    chk("wd_done", wbus.done, 4'b0001);
    chk("wd_err", wbus.err, 1);
    chk("wd_result", wbus.result, 0);
    chk("wd_core_rst_pulses", aborts, 1);
    wbus.req[0] = 1'b0;
    wbus.a_in[8 +: 8] = 8'd12;
    wbus.b_in[8 +: 8] = 8'd8;
    wbus.req[1] = 1'b1;
    cnt = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (wbus.done != 0) begin
        cnt = c;
        break;
      end
    end
    chk("wd_next_in_time", cnt >= 0, 1);
    chk("wd_next_done", wbus.done, 4'b0010);
    chk("wd_next_result", wbus.result, 4);
    chk("wd_next_err", wbus.err, 0);
    wbus.req[1] = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Shared-resource controller that time-multiplexes one `gcd_core` unit between N independent requesters. Each requester presents a pair of operands under a req/done handshake. The arbiter chooses one requester by round-robin, sequences the core's start/ready protocol, and returns the result with a one-cycle done pulse. It also resolves zero-operand requests without using the core, and aborts hung computations with a watchdog.

## Interface
Parameters:
- `N`, 4 — number of requesters (2..8).
- `W`, 8 — operand/result width.
- `TMO`, 1023 — watchdog limit in cycles spent in WAIT; counter width is clog2(TMO+1).

Ports (clock and reset):
- `clk` input 1 — clock; all state updates on the rising edge.
- `rst` input 1 — synchronous, active-high reset.

Ports (requesters):
- `req` input N — request per requester; operands are held stable while high.
- `a_in` input N*W — operands A; requester i uses slice [i*W +: W].
- `b_in` input N*W — operands B; same slicing as `a_in`.
- `grant` output N — one-hot; marks the requester being served.
- `done` output N — one-hot, one-cycle completion pulse.
- `result` output W — GCD value; valid only in the cycle `done` is high.
- `err` output 1 — high together with `done` when the watchdog aborted the request.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If `req` is zero, stay in IDLE.
  - Otherwise pick winner w = first set bit of `req`, searching upward from `ptr` with wrap-around.
  - Latch w, A_w and B_w into internal registers and go to ISSUE.
- ISSUE:
  - If A == 0 or B == 0: bypass the core. Set res = A | B (gcd(0,x) = x, gcd(0,0) = 0) and go to RESP.
  - Otherwise drive `core_start` = 1 for this one cycle, with latched operands on the core inputs. Clear the watchdog counter and go to WAIT.
  - The bypass is mandatory because the core never terminates when one operand is zero.
- WAIT:
  - Core operands stay on the latched registers, stable until the core signals ready.
  - On `core_ready`: res <= core result, err_r <= 0, go to RESP.
  - Otherwise increment the watchdog counter. When it reaches TMO: pulse `core_rst` for one cycle, set res <= 0 and err_r <= 1, then go to RESP.
- RESP:
  - Drive `done[w]` = 1, `result` = res, `err` = err_r.
  - Update `ptr` <= (w+1) mod N and go to IDLE.
- Outputs:
  - `grant[w]` is high from ISSUE through RESP inclusive and is zero in IDLE.
  - `result` and `err` are 0 outside RESP.
- Requester state is never examined mid-service. If `req[w]` drops after being latched, the computation still completes and `done[w]` still pulses.
- A `req` still high after its `done` is treated as a new request. The rotated pointer gives every other pending requester priority first.
- A requester dropping `req` while it is not granted loses nothing; there is no queueing.
- Core reset: `core_rst` = `rst` | abort pulse.

## Timing
- Reset values: state = IDLE, `ptr` = 0, `grant` = 0, `done` = 0, `result` = 0, `err` = 0, `core_start` = 0, watchdog counter = 0.
- Asserting `rst` during any state returns to IDLE on the next edge. No `done` pulse is issued for the aborted request; the core is reset with it.
- Bypass latency: `req` sampled in IDLE at cycle t, ISSUE at t+1, `done` at t+2.
- Core latency: `core_start` at t+1, `done` one cycle after the cycle in which `core_ready` is sampled high. Total = core latency + 3.
- Back-to-back service: the minimum gap between consecutive `done` pulses is 3 cycles (RESP -> IDLE -> ISSUE -> RESP with bypass).
- Watchdog: the abort path produces `done` exactly TMO+2 cycles after `core_start`.
- Simultaneous `req` assertion on all lines resolves purely by `ptr`.

## Structure
- Shared package `gcd_arb_pkg`:
  - state encoding constants (IDLE/ISSUE/WAIT/RESP);
  - default W;
  - round-robin pick function (req vector, ptr -> index, found flag).
- One sub-module, `gcd_core`: the existing subtract/exchange GCD datapath with its FSM.
  - Ports: `clk`, `rst`, `start`, `a`, `b`, `result`, `ready`.
  - `result` is valid in the `ready` cycle.
  - It loads operands in the cycle after `start`; the arbiter holds them stable until `ready`.
  - Instantiated once, with its reset tied to `core_rst`.

## Test plan
- Single request: `req[0]` with A=12, B=8 -> single `done[0]` pulse, `result` = 4, `err` = 0; `grant[0]` high from ISSUE to RESP; no other `grant` bits set.
- Zero bypass: `req[2]` with A=0, B=9 -> `result` = 9 with `done[2]` 2 cycles after sampling; `core_start` never asserted. A=0, B=0 -> `result` = 0.
- Fairness: all four `req` high after reset, with (12,8), (7,7), (255,1), (35,21) -> `done` order 0,1,2,3 with results 4, 7, 1, 7. Then keep `req[0]` and `req[3]` high -> service order 0, 3, 0, 3.
- Watchdog: TMO = 16, core `ready` forced low -> `core_rst` pulse; `done` with `err` = 1 and `result` = 0 exactly 18 cycles after `core_start`. The next request completes normally.
- Reset mid-WAIT: `rst` asserted during computation of (48,18) -> all outputs 0 on the next edge, `ptr` = 0, no `done`. Re-issue -> `result` = 6.
- Drop after grant: `req[1]` deasserted in WAIT for (100,75) -> `done[1]` still pulses with `result` = 25.
